// File: rtl/mac_enc_pkg.sv
// Shared definitions for the egress MAC encoder: header field map, framing
// constants, CRC32 constants and FSM state encoding.
package mac_enc_pkg;

  localparam int HEADER_DWIDTH = 128;
  localparam int HDR_DA_MSB    = 127;   // DA, SA and EtherType are contiguous from here down
  localparam int HDR_BYTES     = 14;
  localparam int PRE_BYTES     = 8;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD           = 8'hD5;
  localparam logic [31:0] CRC_POLY_R    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HLOAD,
    ST_PRE,
    ST_HDR,
    ST_BREQ,
    ST_BWR,
    ST_PAD,
    ST_FCS
  } state_e;

  // Byte i of the on-wire header (0 = DA[47:40] ... 13 = EtherType[7:0]).
  function automatic logic [7:0] hdr_byte(input logic [HEADER_DWIDTH-1:0] h,
                                          input logic [3:0] i);
    return h[HDR_DA_MSB - 8*int'(i) -: 8];
  endfunction

endpackage

// File: rtl/mac_enc_if.sv
// Header FIFO, body FIFO and PHY-TX FIFO connections of the MAC encoder.
interface mac_enc_if;
  import mac_enc_pkg::*;

  logic [HEADER_DWIDTH-1:0] h_fifo_dout;
  logic                     h_fifo_empty;
  logic                     h_fifo_rden;
  logic [7:0]               b_fifo_dout;
  logic                     b_fifo_empty;
  logic                     b_fifo_del;
  logic                     b_fifo_rden;
  logic [7:0]               o_fifo_din;
  logic                     o_fifo_wren;
  logic                     o_fifo_del;
  logic                     o_fifo_afull;
  logic                     frame_done;
  logic                     oversize_err;

  modport master (
    input  h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del, o_fifo_afull,
    output h_fifo_rden, b_fifo_rden, o_fifo_din, o_fifo_wren, o_fifo_del,
           frame_done, oversize_err
  );

  modport slave (
    output h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del, o_fifo_afull,
    input  h_fifo_rden, b_fifo_rden, o_fifo_din, o_fifo_wren, o_fifo_del,
           frame_done, oversize_err
  );
endinterface

// File: rtl/mac_enc_crc32_d8.sv
// Combinational IEEE 802.3 CRC32 step: one byte, LSB first, reflected polynomial.
module crc32_d8
  import mac_enc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_R) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/mac_enc.sv
// Egress MAC encoder: header + body FIFOs in, complete wire frame
// (preamble/SFD, DA, SA, type, body, pad, FCS) out to a PHY-TX FIFO.
module mac_enc
  import mac_enc_pkg::*;
#(
  parameter bit GEN_PREAMBLE = 1'b1,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_BODY     = 1500
) (
  input  logic      clk,
  input  logic      arst_n,
  mac_enc_if.master bus
);

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic [10:0]              len_q, len_d, len_inc;
  logic [10:0]              bcnt_q, bcnt_d, bcnt_inc;
  logic [31:0]              crc_q, crc_d, crc_nx;
  logic [HEADER_DWIDTH-1:0] hdr_q, hdr_d;
  logic [7:0]               wbyte;
  logic [7:0]               din_q, din_d;
  logic                     wren_q, wren_d;
  logic                     del_q, del_d;
  logic                     ovf_q, ovf_d;
  logic                     done_q;
  logic                     armed_q;
  logic                     h_rden, b_rden;
  logic [31:0]              fcs;

  assign fcs      = ~crc_q;
  assign len_inc  = (len_q  == 11'h7FF) ? len_q  : len_q  + 11'd1;
  assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;

  // Byte the current state would emit; also feeds the CRC step.
  always_comb begin
    wbyte = 8'h00;
    case (state_q)
      ST_PRE:  wbyte = (idx_q == 4'd7) ? SFD : PREAMBLE_BYTE;
      ST_HDR:  wbyte = hdr_byte(hdr_q, idx_q);
      ST_BWR:  wbyte = bus.b_fifo_dout;
      ST_FCS: begin
        case (idx_q[1:0])
          2'd0:    wbyte = fcs[7:0];
          2'd1:    wbyte = fcs[15:8];
          2'd2:    wbyte = fcs[23:16];
          default: wbyte = fcs[31:24];
        endcase
      end
      default: wbyte = 8'h00;
    endcase
  end

  crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (wbyte),
    .crc_o  (crc_nx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    crc_d   = crc_q;
    hdr_d   = hdr_q;
    wren_d  = 1'b0;
    din_d   = 8'h00;
    del_d   = 1'b0;
    ovf_d   = 1'b0;
    h_rden  = 1'b0;
    b_rden  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Wait for the previous frame's last byte to leave the output register.
        if (armed_q && !bus.h_fifo_empty && !del_q) begin
          h_rden  = 1'b1;
          state_d = ST_HLOAD;
        end
      end
      ST_HLOAD: begin
        hdr_d   = bus.h_fifo_dout;
        crc_d   = CRC_INIT;
        len_d   = 11'd0;
        bcnt_d  = 11'd0;
        idx_d   = 4'd0;
        state_d = GEN_PREAMBLE ? ST_PRE : ST_HDR;
      end
      ST_PRE: begin
        if (!bus.o_fifo_afull) begin
          wren_d = 1'b1;
          din_d  = wbyte;
          if (idx_q == 4'(PRE_BYTES - 1)) begin
            idx_d   = 4'd0;
            state_d = ST_HDR;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_HDR: begin
        if (!bus.o_fifo_afull) begin
          wren_d = 1'b1;
          din_d  = wbyte;
          crc_d  = crc_nx;
          len_d  = len_inc;
          if (idx_q == 4'(HDR_BYTES - 1)) begin
            idx_d   = 4'd0;
            state_d = ST_BREQ;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      ST_BREQ: begin
        if (!bus.b_fifo_empty && !bus.o_fifo_afull) begin
          b_rden  = 1'b1;
          state_d = ST_BWR;
        end
      end
      ST_BWR: begin
        // FIFO output holds after the pop, so stalling here on afull is safe.
        if (!bus.o_fifo_afull) begin
          wren_d = 1'b1;
          din_d  = wbyte;
          crc_d  = crc_nx;
          len_d  = len_inc;
          bcnt_d = bcnt_inc;
          ovf_d  = (bcnt_q == 11'(MAX_BODY));
          if (bus.b_fifo_del) begin
            idx_d   = 4'd0;
            state_d = (len_d < 11'(MIN_FRAME)) ? ST_PAD : ST_FCS;
          end else begin
            state_d = ST_BREQ;
          end
        end
      end
      ST_PAD: begin
        if (!bus.o_fifo_afull) begin
          wren_d = 1'b1;
          din_d  = wbyte;
          crc_d  = crc_nx;
          len_d  = len_inc;
          if (len_d == 11'(MIN_FRAME)) begin
            idx_d   = 4'd0;
            state_d = ST_FCS;
          end
        end
      end
      ST_FCS: begin
        if (!bus.o_fifo_afull) begin
          wren_d = 1'b1;
          din_d  = wbyte;
          if (idx_q == 4'd3) begin
            del_d   = 1'b1;
            idx_d   = 4'd0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      len_q   <= 11'd0;
      bcnt_q  <= 11'd0;
      crc_q   <= CRC_INIT;
      hdr_q   <= '0;
      wren_q  <= 1'b0;
      din_q   <= 8'h00;
      del_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      crc_q   <= crc_d;
      hdr_q   <= hdr_d;
      wren_q  <= wren_d;
      din_q   <= din_d;
      del_q   <= del_d;
      ovf_q   <= ovf_d;
      done_q  <= del_q;
      armed_q <= 1'b1;
    end
  end

  assign bus.h_fifo_rden  = h_rden;
  assign bus.b_fifo_rden  = b_rden;
  assign bus.o_fifo_din   = din_q;
  assign bus.o_fifo_wren  = wren_q;
  assign bus.o_fifo_del   = del_q;
  assign bus.frame_done   = done_q;
  assign bus.oversize_err = ovf_q;

endmodule

// File: tb/tb_mac_enc.sv
// Scoreboard bench for mac_enc: expected frames are queued at stimulus time,
// a negedge monitor pops and compares every PHY-TX write.
module tb_mac_enc;
  import mac_enc_pkg::*;

  typedef struct packed {
    logic [7:0] b;
    logic       del;
    logic       ovf;
  } exp_t;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;

  mac_enc_if ifc ();

  mac_enc #(
    .GEN_PREAMBLE (1'b1),
    .MIN_FRAME    (60),
    .MAX_BODY     (1500)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (ifc.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [HEADER_DWIDTH-1:0] hq[$];
  logic [8:0]               bq[$];
  exp_t                     exp_q[$];
  int                       frame_lens[$];

  int          wcount    = 0;
  int          total_wr  = 0;
  int          done_cnt  = 0;
  int          ovf_cnt   = 0;
  int          hpops     = 0;
  bit          in_flight = 1'b0;
  bit          del_prev  = 1'b0;
  bit          afull_prev = 1'b0;
  logic [31:0] crc_run   = 32'hFFFF_FFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'h0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [7:0] body_byte(input int seed, input int i);
    return 8'(seed + i * 13);
  endfunction

  function automatic void exp_push(input logic [7:0] b, input logic del, input logic ovf);
    exp_t e;
    e.b = b; e.del = del; e.ovf = ovf;
    exp_q.push_back(e);
  endfunction

  // Build the expected wire frame and optionally load the body FIFO model.
  task automatic push_frame(input logic [127:0] hdr, input int nbody, input int seed,
                            input bit with_body);
    logic [31:0] c;
    logic [7:0]  b;
    logic [8:0]  be;
    int          len;
    c   = 32'hFFFF_FFFF;
    len = 0;
    for (int i = 0; i < 7; i++) exp_push(8'h55, 1'b0, 1'b0);
    exp_push(8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      b = hdr[127 - 8*i -: 8];
      exp_push(b, 1'b0, 1'b0);
      c = crc_upd(c, b);
      len++;
    end
    for (int i = 0; i < nbody; i++) begin
      b = body_byte(seed, i);
      exp_push(b, 1'b0, (i + 1) == 1501);
      c = crc_upd(c, b);
      len++;
      if (with_body) begin
        be = {(i == nbody - 1), b};
        bq.push_back(be);
      end
    end
    while (len < 60) begin
      exp_push(8'h00, 1'b0, 1'b0);
      c = crc_upd(c, 8'h00);
      len++;
    end
    c = ~c;
    exp_push(c[7:0],   1'b0, 1'b0);
    exp_push(c[15:8],  1'b0, 1'b0);
    exp_push(c[23:16], 1'b0, 1'b0);
    exp_push(c[31:24], 1'b1, 1'b0);
    hq.push_back(hdr);
  endtask

  task automatic push_body(input int nbody, input int seed, input int from, input int upto);
    logic [8:0] be;
    for (int i = from; i < upto; i++) begin
      be = {(i == nbody - 1), body_byte(seed, i)};
      bq.push_back(be);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_flight) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= budget), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Header/body FIFO models: pop on rden, data valid the following cycle.
  always @(posedge clk or negedge arst_n) begin
    logic [8:0] be;
    if (!arst_n) begin
      hq.delete();
      bq.delete();
      ifc.h_fifo_dout  <= '0;
      ifc.h_fifo_empty <= 1'b1;
      ifc.b_fifo_dout  <= 8'h00;
      ifc.b_fifo_del   <= 1'b0;
      ifc.b_fifo_empty <= 1'b1;
    end else begin
      if (ifc.h_fifo_rden && hq.size() > 0) ifc.h_fifo_dout <= hq.pop_front();
      ifc.h_fifo_empty <= (hq.size() == 0);
      if (ifc.b_fifo_rden && bq.size() > 0) begin
        be = bq.pop_front();
        ifc.b_fifo_dout <= be[7:0];
        ifc.b_fifo_del  <= be[8];
      end
      ifc.b_fifo_empty <= (bq.size() == 0);
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!arst_n) begin
      wcount     = 0;
      crc_run    = 32'hFFFF_FFFF;
      in_flight  = 1'b0;
      del_prev   = 1'b0;
      afull_prev = 1'b0;
    end else begin
      if (ifc.frame_done || del_prev) check("frame_done_timing", ifc.frame_done, del_prev);
      if (ifc.frame_done) done_cnt++;
      if (ifc.h_fifo_rden) begin
        check("hdr_pop_after_del", in_flight, 1'b0);
        in_flight = 1'b1;
        hpops++;
      end
      if (ifc.oversize_err) ovf_cnt++;
      if (ifc.o_fifo_wren) begin
        total_wr++;
        check("wren_while_afull", afull_prev, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("din",          ifc.o_fifo_din,   e.b);
          check("o_fifo_del",   ifc.o_fifo_del,   e.del);
          check("oversize_err", ifc.oversize_err, e.ovf);
        end
        wcount++;
        if (wcount > 8) crc_run = crc_upd(crc_run, ifc.o_fifo_din);
        if (ifc.o_fifo_del) begin
          check("fcs_residue", crc_run, CRC_RESIDUE);
          frame_lens.push_back(wcount);
          wcount    = 0;
          crc_run   = 32'hFFFF_FFFF;
          in_flight = 1'b0;
        end
      end else if (ifc.oversize_err || ifc.o_fifo_del) begin
        check("strobe_without_wren", 32'd1, 32'd0);
      end
      del_prev   = ifc.o_fifo_wren && ifc.o_fifo_del;
      afull_prev = ifc.o_fifo_afull;
    end
  end

  localparam logic [127:0] H_ARP = {48'hFFFF_FFFF_FFFF, 48'h0011_2233_4455, 16'h0806, 16'h0000};
  localparam logic [127:0] H_IP  = {48'h0A0B_0C0D_0E0F, 48'h0011_2233_4455, 16'h0800, 16'h0000};
  localparam logic [127:0] H_X   = {48'h0200_0000_0001, 48'h0200_0000_0002, 16'h88B5, 16'h0000};

  initial begin
    int d0, h0, o0, w0, n;
    logic [6:0] outs;
    ifc.o_fifo_afull = 1'b0;

    repeat (3) @(negedge clk);
    outs = {ifc.h_fifo_rden, ifc.b_fifo_rden, ifc.o_fifo_wren, ifc.o_fifo_del,
            ifc.frame_done, ifc.oversize_err, |ifc.o_fifo_din};
    check("reset_outputs", outs, 7'd0);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 28-byte ARP-sized body: padded to 60, 72 writes in total
    push_frame(H_ARP, 28, 1, 1'b1);
    drain(1000);
    check("len_28B_body", frame_lens[$], 32'd72);
    $display("frame 28B body: %0d writes", frame_lens[$]);

    // 46-byte body: no pad, 64 bytes DA..FCS
    push_frame(H_IP, 46, 7, 1'b1);
    drain(1000);
    check("len_46B_body", frame_lens[$], 32'd72);
    $display("frame 46B body: %0d writes", frame_lens[$]);

    // 1500 and 1501 byte bodies around the oversize threshold
    o0 = ovf_cnt;
    push_frame(H_IP, 1500, 3, 1'b1);
    drain(5000);
    check("len_1500B_body", frame_lens[$], 32'd1526);
    check("ovf_1500", ovf_cnt - o0, 32'd0);
    $display("frame 1500B body: %0d writes, oversize %0d", frame_lens[$], ovf_cnt - o0);

    o0 = ovf_cnt;
    push_frame(H_IP, 1501, 5, 1'b1);
    drain(5000);
    check("len_1501B_body", frame_lens[$], 32'd1527);
    check("ovf_1501", ovf_cnt - o0, 32'd1);
    $display("frame 1501B body: %0d writes, oversize %0d", frame_lens[$], ovf_cnt - o0);

    // afull held 50 cycles mid-body, then toggled each cycle
    push_frame(H_X, 200, 9, 1'b1);
    fork
      drain(5000);
      begin
        n = 0;
        while (wcount < 62 && n < 2000) begin
          @(negedge clk);
          n++;
        end
        check("afull_wait_timeout", 32'(n >= 2000), 32'd0);
        @(posedge clk); #1 ifc.o_fifo_afull = 1'b1;
        repeat (50) @(posedge clk);
        for (int i = 0; i < 100; i++) begin
          @(posedge clk); #1 ifc.o_fifo_afull = ~ifc.o_fifo_afull;
        end
        @(posedge clk); #1 ifc.o_fifo_afull = 1'b0;
      end
    join
    drain(2000);
    check("len_afull", frame_lens[$], 32'd226);
    $display("frame with afull stalls: %0d writes", frame_lens[$]);

    // Body FIFO runs dry after byte 10 for 100 cycles
    push_frame(H_ARP, 60, 11, 1'b0);
    push_body(60, 11, 0, 10);
    n = 0;
    while (wcount < 32 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("stall_wait_timeout", 32'(n >= 500), 32'd0);
    repeat (3) @(negedge clk);
    w0 = total_wr;
    repeat (100) @(negedge clk);
    check("no_write_while_body_empty", total_wr - w0, 32'd0);
    push_body(60, 11, 10, 60);
    drain(2000);
    check("len_body_stall", frame_lens[$], 32'd86);
    $display("frame with body stall: %0d writes", frame_lens[$]);

    // Three headers queued back to back
    d0 = done_cnt;
    h0 = hpops;
    push_frame(H_ARP, 28, 21, 1'b1);
    push_frame(H_IP, 46, 22, 1'b1);
    push_frame(H_X, 100, 23, 1'b1);
    drain(3000);
    check("b2b_frame_done", done_cnt - d0, 32'd3);
    check("b2b_hdr_pops", hpops - h0, 32'd3);
    $display("back-to-back: %0d frame_done, %0d header pops", done_cnt - d0, hpops - h0);

    // Async reset in the middle of the header bytes
    push_frame(H_IP, 40, 31, 1'b1);
    n = 0;
    while (wcount < 13 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reset_wait_timeout", 32'(n >= 500), 32'd0);
    #1 arst_n = 1'b0;
    #1;
    outs = {ifc.h_fifo_rden, ifc.b_fifo_rden, ifc.o_fifo_wren, ifc.o_fifo_del,
            ifc.frame_done, ifc.oversize_err, |ifc.o_fifo_din};
    check("async_reset_outputs", outs, 7'd0);
    $display("async reset mid-header: outputs %b", outs);
    exp_q.delete();
    repeat (3) @(negedge clk);
    exp_q.delete();
    arst_n = 1'b1;
    repeat (2) @(negedge clk);

    push_frame(H_ARP, 28, 41, 1'b1);
    drain(1000);
    check("len_after_reset", frame_lens[$], 32'd72);
    $display("frame after reset: %0d writes", frame_lens[$]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
